// File: rtl/program_loader.sv
// Serial byte-stream loader: packs big-endian bytes into words and writes imem from address 0 (PROGRAM_LOADER_CHECKSUM_EN adds a trailing XOR check).
// Latency: write pulse one edge after the fourth byte is sampled; DONE one edge after the halt word write.
// Backpressure: none; accepts a byte every cycle in LOAD and drops rx_valid in IDLE/DONE/ERROR.
module program_loader #(
   parameter int          ADDR_WIDTH = 10,
   parameter logic [31:0] HALT_WORD  = 32'hFFFFFFFF
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [7:0]            rx_data,
   input  logic                  rx_valid,
   input  logic                  start,
   output logic                  imem_we,
   output logic [ADDR_WIDTH-1:0] imem_addr,
   output logic [31:0]           imem_wdata,
   output logic                  cpu_hold,
   output logic                  busy,
   output logic                  done,
   output logic                  error,
   output logic [ADDR_WIDTH:0]   word_count
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_DONE  = 3'd2,
      S_ERROR = 3'd3
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      , S_CHECK = 3'd4
`endif
   } state_t;

   state_t                state_q, state_d;
   logic [1:0]            byte_cnt_q, byte_cnt_d;
   logic [31:0]           shift_q, shift_d;
   logic                  word_rdy_q, word_rdy_d;
   logic                  imem_we_q, imem_we_d;
   logic [ADDR_WIDTH-1:0] imem_addr_q, imem_addr_d;
   logic [31:0]           imem_wdata_q, imem_wdata_d;
   logic [ADDR_WIDTH:0]   word_count_q, word_count_d;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
   logic [7:0]            csum_q, csum_d;
`endif

   logic session_open;
   logic overflow;
   logic halt_written;

   assign session_open = start && (state_q == S_IDLE || state_q == S_DONE || state_q == S_ERROR);
   // Top bit of word_count set means every address has already been used.
   assign overflow     = word_rdy_q && word_count_q[ADDR_WIDTH];
   assign halt_written = imem_we_q && (imem_wdata_q == HALT_WORD);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q      <= S_IDLE;
         byte_cnt_q   <= '0;
         shift_q      <= '0;
         word_rdy_q   <= 1'b0;
         imem_we_q    <= 1'b0;
         imem_addr_q  <= '0;
         imem_wdata_q <= '0;
         word_count_q <= '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
         csum_q       <= '0;
`endif
      end else begin
         state_q      <= state_d;
         byte_cnt_q   <= byte_cnt_d;
         shift_q      <= shift_d;
         word_rdy_q   <= word_rdy_d;
         imem_we_q    <= imem_we_d;
         imem_addr_q  <= imem_addr_d;
         imem_wdata_q <= imem_wdata_d;
         word_count_q <= word_count_d;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
         csum_q       <= csum_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:  if (start) state_d = S_LOAD;
         S_LOAD: begin
            if (overflow) begin
               state_d = S_ERROR;
            end else if (halt_written) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
               state_d = S_CHECK;
`else
               state_d = S_DONE;
`endif
            end
         end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
         S_CHECK: if (rx_valid) state_d = (rx_data == csum_q) ? S_DONE : S_ERROR;
`endif
         S_DONE:  if (start) state_d = S_LOAD;
         S_ERROR: if (start) state_d = S_LOAD;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      byte_cnt_d   = byte_cnt_q;
      shift_d      = shift_q;
      word_rdy_d   = 1'b0;
      imem_we_d    = 1'b0;
      imem_addr_d  = imem_addr_q;
      imem_wdata_d = imem_wdata_q;
      word_count_d = word_count_q;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      csum_d       = csum_q;
`endif
      if (session_open) begin
         byte_cnt_d   = '0;
         imem_addr_d  = '0;
         word_count_d = '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
         csum_d       = '0;
`endif
      end else if (state_q == S_LOAD) begin
         if (rx_valid) begin
            shift_d    = {shift_q[23:0], rx_data};
            byte_cnt_d = byte_cnt_q + 2'd1;
            word_rdy_d = (byte_cnt_q == 2'd3);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            csum_d     = csum_q ^ rx_data;
`endif
         end
         // shift_q still holds the completed word even if the next byte lands this edge.
         if (word_rdy_q && !overflow) begin
            imem_we_d    = 1'b1;
            imem_wdata_d = shift_q;
            imem_addr_d  = word_count_q[ADDR_WIDTH-1:0];
            word_count_d = word_count_q + (ADDR_WIDTH+1)'(1);
         end
      end
   end

   always_comb begin
      imem_we    = imem_we_q;
      imem_addr  = imem_addr_q;
      imem_wdata = imem_wdata_q;
      word_count = word_count_q;
      cpu_hold   = (state_q != S_DONE);
      done       = (state_q == S_DONE);
      error      = (state_q == S_ERROR);
      busy       = (state_q == S_LOAD);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      busy       = (state_q == S_LOAD) || (state_q == S_CHECK);
`endif
   end

endmodule
